// File: rtl/prog_loader.sv
// Serial program loader: 8N1 UART receiver feeding a framed RAM image
// writer that holds the CPU in reset until the checksum verifies.
module prog_loader #(
    parameter int         CLKS_PER_BIT = 16,
    parameter logic [7:0] SYNC_BYTE    = 8'hA5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    output logic       prog,
    output logic [3:0] addr,
    output logic [7:0] prog_data,
    output logic       cpu_reset,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        R_IDLE,
        R_START,
        R_DATA,
        R_STOP,
        R_WAIT
    } rx_state_t;

    typedef enum logic [2:0] {
        L_IDLE,
        L_LOAD,
        L_CHECK,
        L_DONE,
        L_ERR
    } ld_state_t;

    logic          rx_meta;
    logic          rx_sync;
    rx_state_t     rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_valid;
    logic          rx_ferr;

    ld_state_t     ld_state;
    logic [3:0]    idx;
    logic [7:0]    csum;
    logic          prog_d;

    // Two-flop synchronizer for the asynchronous serial line (idle high)
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
        end
    end

    // UART receiver: start-bit qualify, mid-bit data/stop sampling
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_state <= R_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            case (rx_state)
                R_IDLE: begin
                    rx_cnt <= '0;
                    if (!rx_sync) begin
                        rx_state <= R_START;
                    end
                end
                R_START: begin
                    if (rx_cnt == HALF) begin
                        rx_cnt <= '0;
                        rx_bit <= '0;
                        if (rx_sync) begin
                            rx_state <= R_IDLE;
                        end else begin
                            rx_state <= R_DATA;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (rx_cnt == FULL) begin
                        rx_cnt   <= '0;
                        rx_shift <= {rx_sync, rx_shift[7:1]};
                        if (rx_bit == 3'd7) begin
                            rx_state <= R_STOP;
                        end else begin
                            rx_bit <= rx_bit + 1'b1;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (rx_cnt == FULL) begin
                        rx_cnt <= '0;
                        if (rx_sync) begin
                            rx_valid <= 1'b1;
                            rx_state <= R_IDLE;
                        end else begin
                            rx_ferr  <= 1'b1;
                            rx_state <= R_WAIT;
                        end
                    end else begin
                        rx_cnt <= rx_cnt + 1'b1;
                    end
                end
                R_WAIT: begin
                    if (rx_sync) begin
                        rx_state <= R_IDLE;
                    end
                end
                default: begin
                    rx_state <= R_IDLE;
                end
            endcase
        end
    end

    // Loader FSM: sync detect, 16 RAM writes, checksum verdict
    always_ff @(posedge clk) begin
        if (reset) begin
            ld_state  <= L_IDLE;
            idx       <= '0;
            csum      <= '0;
            prog      <= 1'b0;
            prog_d    <= 1'b0;
            addr      <= '0;
            prog_data <= '0;
            cpu_reset <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            error     <= 1'b0;
        end else begin
            prog   <= 1'b0;
            prog_d <= prog;
            case (ld_state)
                L_LOAD: begin
                    if (rx_ferr) begin
                        ld_state <= L_ERR;
                        error    <= 1'b1;
                        busy     <= 1'b0;
                    end else if (rx_valid) begin
                        prog      <= 1'b1;
                        addr      <= idx;
                        prog_data <= rx_shift;
                        csum      <= csum + rx_shift;
                        idx       <= idx + 1'b1;
                        if (idx == 4'd15) begin
                            ld_state <= L_CHECK;
                        end
                    end
                end
                L_CHECK: begin
                    // addr follows the wrapped index once the last
                    // write has had its hold cycle
                    if (prog_d) begin
                        addr <= idx;
                    end
                    if (rx_ferr) begin
                        ld_state <= L_ERR;
                        error    <= 1'b1;
                        busy     <= 1'b0;
                    end else if (rx_valid) begin
                        busy <= 1'b0;
                        if (rx_shift == csum) begin
                            ld_state  <= L_DONE;
                            done      <= 1'b1;
                            cpu_reset <= 1'b0;
                        end else begin
                            ld_state <= L_ERR;
                            error    <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (rx_valid && rx_shift == SYNC_BYTE) begin
                        ld_state  <= L_LOAD;
                        idx       <= '0;
                        csum      <= '0;
                        cpu_reset <= 1'b1;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        error     <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: byte-level reference model, per-strobe
// compare process and per-frame flag checks.
module tb_prog_loader;

    localparam int CPB = 8;

    logic       clk;
    logic       reset;
    logic       rx;
    logic       prog;
    logic [3:0] addr;
    logic [7:0] prog_data;
    logic       cpu_reset;
    logic       busy;
    logic       done;
    logic       error;

    prog_loader #(
        .CLKS_PER_BIT(CPB),
        .SYNC_BYTE   (8'hA5)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .rx       (rx),
        .prog     (prog),
        .addr     (addr),
        .prog_data(prog_data),
        .cpu_reset(cpu_reset),
        .busy     (busy),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int pulses = 0;

    typedef struct packed {
        logic [3:0] a;
        logic [7:0] d;
    } wr_t;

    wr_t        exp_q[$];
    logic [7:0] mem[16];

    // model state: 0 idle, 1 load, 2 check, 3 done, 4 err
    int         m_st;
    logic [3:0] m_idx;
    logic [7:0] m_sum;
    bit         m_done;
    bit         m_err;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    function automatic void model_reset();
        m_st   = 0;
        m_idx  = '0;
        m_sum  = '0;
        m_done = 0;
        m_err  = 0;
        exp_q.delete();
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        if (m_st == 1) begin
            exp_q.push_back('{a: m_idx, d: b});
            m_sum = m_sum + b;
            if (m_idx == 4'd15) m_st = 2;
            m_idx = m_idx + 4'd1;
        end else if (m_st == 2) begin
            if (b == m_sum) begin
                m_st   = 3;
                m_done = 1;
            end else begin
                m_st  = 4;
                m_err = 1;
            end
        end else if (b == 8'hA5) begin
            m_st   = 1;
            m_idx  = '0;
            m_sum  = '0;
            m_done = 0;
            m_err  = 0;
        end
    endfunction

    function automatic void model_ferr();
        if (m_st == 1 || m_st == 2) begin
            m_st  = 4;
            m_err = 1;
        end
    endfunction

    // compare process: every write strobe against the model queue
    bit         prev_prog = 0;
    logic [3:0] last_a;
    logic [7:0] last_d;
    always @(negedge clk) begin
        if (!reset) begin
            if (prev_prog) begin
                chk("prog_width", int'(prog), 0);
                chk("addr_hold", int'(addr), int'(last_a));
                chk("data_hold", int'(prog_data), int'(last_d));
            end
            if (prog) begin
                pulses++;
                mem[addr] = prog_data;
                last_a = addr;
                last_d = prog_data;
                chk("busy_in_load", int'(busy), 1);
                chk("cpu_rst_in_load", int'(cpu_reset), 1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_prog", int'(addr), -1);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    chk("prog_addr", int'(addr), int'(e.a));
                    chk("prog_data", int'(prog_data), int'(e.d));
                end
            end
        end
        prev_prog = prog && !reset;
    end

    task automatic line(input logic v, input int n);
        rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input bit stop_ok);
        if (stop_ok) model_byte(b);
        else model_ferr();
        line(1'b0, CPB);
        for (int i = 0; i < 8; i++) line(b[i], CPB);
        line(stop_ok, CPB);
        if (!stop_ok) line(1'b1, CPB);
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic chk_reset_vals();
        chk("rst_prog", int'(prog), 0);
        chk("rst_addr", int'(addr), 0);
        chk("rst_data", int'(prog_data), 0);
        chk("rst_cpu_reset", int'(cpu_reset), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_error", int'(error), 0);
    endtask

    task automatic chk_flags(input string nm);
        bit b;
        line(1'b1, 3 * CPB);
        b = (m_st == 1 || m_st == 2);
        chk({nm, "_done"}, int'(done), int'(m_done));
        chk({nm, "_error"}, int'(error), int'(m_err));
        chk({nm, "_busy"}, int'(busy), int'(b));
        chk({nm, "_cpu_reset"}, int'(cpu_reset), int'(b || m_err));
        chk({nm, "_missing"}, exp_q.size(), 0);
    endtask

    task automatic send_frame(input logic [7:0] img[16],
                              input logic [7:0] cs);
        send(8'hA5, 1);
        for (int i = 0; i < 16; i++) send(img[i], 1);
        send(cs, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] img[16];
        logic [7:0] s;
        int         p0;
        int         fpos;
        bit         bad_cs;

        reset = 1'b1;
        rx = 1'b1;
        model_reset();
        @(posedge clk);
        #1;

        // reset values, then a stray byte with no sync
        do_reset(3);
        chk_reset_vals();
        send(8'h55, 1);
        line(1'b1, 3 * CPB);
        chk("no_sync_prog", pulses, 0);

        // good load
        for (int i = 0; i < 16; i++) img[i] = 8'(i);
        send_frame(img, 8'h78);
        chk_flags("good");
        chk("good_pulses", pulses, 16);
        chk("good_done", int'(done), 1);
        chk("good_cpu_reset", int'(cpu_reset), 0);
        chk("good_error", int'(error), 0);
        chk("good_addr_wrap", int'(addr), 0);
        for (int i = 0; i < 16; i++) chk("good_ram", int'(mem[i]), i);

        // bad checksum, then recovery
        send_frame(img, 8'h79);
        chk_flags("badcs");
        chk("badcs_pulses", pulses, 32);
        chk("badcs_error", int'(error), 1);
        chk("badcs_cpu_reset", int'(cpu_reset), 1);
        chk("badcs_done", int'(done), 0);
        send_frame(img, 8'h78);
        chk_flags("recover");
        chk("recover_done", int'(done), 1);

        // leading garbage and a short glitch before sync
        do_reset(2);
        p0 = pulses;
        send(8'h12, 1);
        send(8'hFF, 1);
        line(1'b0, 3);
        line(1'b1, 2 * CPB);
        chk("garbage_prog", pulses - p0, 0);
        for (int i = 0; i < 16; i++) img[i] = 8'h01;
        send_frame(img, 8'h10);
        chk_flags("garbage");
        chk("garbage_done", int'(done), 1);

        // framing error after five data bytes
        p0 = pulses;
        send(8'hA5, 1);
        for (int i = 0; i < 5; i++) send(8'($urandom), 1);
        send(8'h3C, 0);
        chk_flags("ferr");
        chk("ferr_pulses", pulses - p0, 5);
        chk("ferr_error", int'(error), 1);
        chk("ferr_cpu_reset", int'(cpu_reset), 1);

        // reset in the middle of a load
        send(8'hA5, 1);
        for (int i = 0; i < 7; i++) send(8'($urandom), 1);
        line(1'b1, 2 * CPB);
        do_reset(1);
        chk_reset_vals();
        s = '0;
        for (int i = 0; i < 16; i++) begin
            img[i] = 8'($urandom);
            s = s + img[i];
        end
        send_frame(img, s);
        chk_flags("midrst");

        // randomized frames: garbage, gaps, bad sums, framing errors
        for (int f = 0; f < 18; f++) begin
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                send(8'($urandom_range(0, 8'hA4)), 1);
            end
            s = '0;
            for (int i = 0; i < 16; i++) begin
                img[i] = 8'($urandom);
                s = s + img[i];
            end
            bad_cs = ($urandom_range(0, 3) == 0);
            fpos = ($urandom_range(0, 9) == 0) ?
                   int'($urandom_range(0, 16)) : -1;
            send(8'hA5, 1);
            for (int i = 0; i <= 16; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    line(1'b1, int'($urandom_range(1, 2 * CPB)));
                end
                if (i == fpos) begin
                    send(8'($urandom), 0);
                    break;
                end
                if (i < 16) send(img[i], 1);
                else send(bad_cs ? s + 8'd1 : s, 1);
            end
            chk_flags("rand");
            if (fpos < 0) begin
                for (int i = 0; i < 16; i++) begin
                    chk("rand_ram", int'(mem[i]), int'(img[i]));
                end
            end
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
